// File: rtl/six_bit_adder.sv
// Registered 6-bit adder built from two 3-bit carry-lookahead groups.
// Captures an operation on in_valid and presents flags plus a one-cycle out_valid strobe.
module six_bit_adder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [5:0] A,
  input  logic [5:0] B,
  input  logic       C0,
  output logic [5:0] S,
  output logic       Cout,
  output logic       ovf,
  output logic       zero,
  output logic       out_valid
);

  // Returns {c3,c2,c1,c0} for a 3-bit lookahead group; c3 feeds the next group.
  function automatic logic [3:0] cla3(input logic [2:0] g, input logic [2:0] p,
                                      input logic cin);
    logic [3:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  logic [5:0] gen_s;
  logic [5:0] prop_s;
  logic [3:0] lo_carry_s;
  logic [3:0] hi_carry_s;
  logic [6:0] carry_s;
  logic [5:0] sum_s;

  logic [5:0] s_r;
  logic       cout_r;
  logic       ovf_r;
  logic       zero_r;
  logic       out_valid_r;

  // Combinational sum: per-bit generate/propagate, low group carry chains into high group.
  always_comb begin
    gen_s      = A & B;
    prop_s     = A ^ B;
    lo_carry_s = cla3(gen_s[2:0], prop_s[2:0], C0);
    hi_carry_s = cla3(gen_s[5:3], prop_s[5:3], lo_carry_s[3]);
    carry_s    = {hi_carry_s, lo_carry_s[2:0]};
    sum_s      = prop_s ^ carry_s[5:0];
  end

  // Result registers: capture on in_valid, otherwise hold the last result and drop the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_r         <= 6'b000000;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b1;
      out_valid_r <= 1'b0;
    end else if (in_valid) begin
      s_r         <= sum_s;
      cout_r      <= carry_s[6];
      ovf_r       <= carry_s[5] ^ carry_s[6];
      zero_r      <= (sum_s == 6'b000000);
      out_valid_r <= 1'b1;
    end else begin
      s_r         <= s_r;
      cout_r      <= cout_r;
      ovf_r       <= ovf_r;
      zero_r      <= zero_r;
      out_valid_r <= 1'b0;
    end
  end

  assign S         = s_r;
  assign Cout      = cout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_six_bit_adder.sv
// Scoreboard bench for six_bit_adder: directed vectors, burst, reset and exhaustive sweep.
module tb_six_bit_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [5:0] A;
  logic [5:0] B;
  logic       C0;
  logic [5:0] S;
  logic       Cout;
  logic       ovf;
  logic       zero;
  logic       out_valid;

  typedef struct {
    logic [5:0] s;
    logic       cout;
    logic       ovf;
    logic       zero;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  six_bit_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .C0        (C0),
    .S         (S),
    .Cout      (Cout),
    .ovf       (ovf),
    .zero      (zero),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [9:0] got, input logic [9:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest expected result at its expected cycle.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid cyc=%0d S=%b", cyc, S);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (S !== e.s || Cout !== e.cout || ovf !== e.ovf || zero !== e.zero || cyc != e.cyc) begin
          errors++;
          $display("FAIL result cyc=%0d got S=%b Cout=%b ovf=%b zero=%b want S=%b Cout=%b ovf=%b zero=%b cyc=%0d",
                   cyc, S, Cout, ovf, zero, e.s, e.cout, e.ovf, e.zero, e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic [5:0] a, input logic [5:0] b, input logic c,
                       input logic [5:0] es, input logic ecout, input logic eovf,
                       input logic ezero);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    A = a;
    B = b;
    C0 = c;
    e.s = es; e.cout = ecout; e.ovf = eovf; e.zero = ezero; e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = 6'bxxxxxx;
    B = 6'bxxxxxx;
    C0 = 1'bx;
  endtask

  // Reference model: plain integer add, overflow from operand/result sign bits.
  task automatic issue_model(input logic [5:0] a, input logic [5:0] b, input logic c);
    logic [6:0] sum;
    logic       v;
    sum = {1'b0, a} + {1'b0, b} + {6'b000000, c};
    v = (a[5] == b[5]) && (sum[5] != a[5]);
    issue(a, b, c, sum[5:0], sum[6], v, sum[5:0] == 6'b000000);
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b1;
    A = 6'b010101;
    B = 6'b001010;
    C0 = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {S, Cout, ovf, zero, out_valid}, {6'b000000, 1'b0, 1'b0, 1'b1, 1'b0});
    rst_n = 1'b1;
    in_valid = 1'b0;

    issue(6'b001101, 6'b001111, 1'b0, 6'b011100, 1'b0, 1'b0, 1'b0);
    issue(6'b101110, 6'b011100, 1'b1, 6'b001011, 1'b1, 1'b0, 1'b0);
    issue(6'b111111, 6'b000000, 1'b1, 6'b000000, 1'b1, 1'b0, 1'b1);
    issue(6'b111111, 6'b111111, 1'b1, 6'b111111, 1'b1, 1'b0, 1'b0);
    issue(6'b011111, 6'b000001, 1'b0, 6'b100000, 1'b0, 1'b1, 1'b0);
    issue(6'b100000, 6'b100000, 1'b0, 6'b000000, 1'b1, 1'b1, 1'b1);
    idle();
    idle();

    // Three-deep burst, then hold check with X operands on the idle bus.
    issue(6'd5,  6'd7,  1'b0, 6'b001100, 1'b0, 1'b0, 1'b0);
    issue(6'd20, 6'd30, 1'b1, 6'b110011, 1'b0, 1'b1, 1'b0);
    issue(6'd40, 6'd50, 1'b0, 6'b011010, 1'b1, 1'b1, 1'b0);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("hold_after_burst", {S, Cout, ovf, zero, out_valid}, {6'b011010, 1'b1, 1'b1, 1'b0, 1'b0});

    // Reset between edges with an operation presented: it must be dropped.
    in_valid = 1'b1;
    A = 6'd1;
    B = 6'd2;
    C0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {S, Cout, ovf, zero, out_valid}, {6'b000000, 1'b0, 1'b0, 1'b1, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ignores_in", {S, Cout, ovf, zero, out_valid}, {6'b000000, 1'b0, 1'b0, 1'b1, 1'b0});
    in_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 8192; i++) begin
      logic [12:0] v;
      v = i[12:0];
      issue_model(v[11:6], v[5:0], v[12]);
    end
    idle();

    begin
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 20) begin
        @(posedge clk);
        budget++;
      end
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
